// File: rtl/sap_core_if.sv
// Memory port of the accumulator core: address/request out, read data and ready back.
// Latency set by the memory (completes on the edge where mem_ready=1); the core holds each request until then.
interface sap_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_ren, mem_wen, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_ren, mem_wen, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/sap_core.sv
// Parametrised SAP-style accumulator core: 2 cycles per register op, 3 per memory op (+1 per wait).
// Backpressure: any memory request is held stable until mem_ready; run=0 parks the core at the next fetch.
module sap_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              run,
    sap_core_if.master        mem,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [DATA_W-1:0] a_dbg,
    output logic              carry,
    output logic              zero
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_vld_q, out_vld_d;
    logic              c_q, c_d;
    logic              z_q, z_d;

    logic [ADDR_W-1:0] addr_c;
    logic              ren_c;
    logic              wen_c;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    state_t            after_instr;
    logic [DATA_W:0]   add_res;
    logic [DATA_W:0]   sub_res;

    assign opcode  = ir_q[DATA_W-1 -: 4];
    assign operand = ir_q[ADDR_W-1:0];
    // run is only looked at when a new fetch would begin
    assign after_instr = run ? S_FETCH : S_IDLE;
    assign add_res = {1'b0, a_q} + {1'b0, mem.mem_rdata};
    assign sub_res = {1'b0, a_q} + {1'b0, ~mem.mem_rdata} + {{DATA_W{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        c_d       = c_q;
        z_d       = z_q;
        addr_c    = '0;
        ren_c     = 1'b0;
        wen_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ren_c  = 1'b1;
                addr_c = pc_q;
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = after_instr;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = S_MEM;
                    OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
                    OP_JMP: pc_d = operand;
                    OP_JC:  if (c_q) pc_d = operand;
                    OP_JZ:  if (z_q) pc_d = operand;
                    OP_OUT: begin
                        out_d     = a_q;
                        out_vld_d = 1'b1;
                    end
                    OP_HLT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_MEM: begin
                addr_c = operand;
                wen_c  = (opcode == OP_STA);
                ren_c  = (opcode != OP_STA);
                if (mem.mem_ready) begin
                    state_d = after_instr;
                    case (opcode)
                        OP_LDA: a_d = mem.mem_rdata;
                        OP_ADD: begin
                            {c_d, a_d} = add_res;
                            z_d        = (add_res[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            {c_d, a_d} = sub_res;
                            z_d        = (sub_res[DATA_W-1:0] == '0);
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                    pc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            c_q       <= c_d;
            z_q       <= z_d;
        end
    end

    assign mem.mem_addr  = addr_c;
    assign mem.mem_ren   = ren_c;
    assign mem.mem_wen   = wen_c;
    assign mem.mem_wdata = a_q;
    assign out_data      = out_q;
    assign out_valid     = out_vld_q;
    assign halted        = (state_q == S_HALT);
    assign pc_dbg        = pc_q;
    assign a_dbg         = a_q;
    assign carry         = c_q;
    assign zero          = z_q;
endmodule
